// File: rtl/alu_share_arbiter.sv
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Round-robin sharing of one combinational ALU between two
//             requesters, with a 1-deep registered response buffer each.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [OPCODE_LENGTH-1:0] req_op0,
  input  logic [OPCODE_LENGTH-1:0] req_op1,
  input  logic [DATA_WIDTH-1:0]    req_a0,
  input  logic [DATA_WIDTH-1:0]    req_a1,
  input  logic [DATA_WIDTH-1:0]    req_b0,
  input  logic [DATA_WIDTH-1:0]    req_b1,
  input  logic [TAG_WIDTH-1:0]     req_tag0,
  input  logic [TAG_WIDTH-1:0]     req_tag1,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic [1:0]               rsp_valid,
  input  logic [1:0]               rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data0,
  output logic [DATA_WIDTH-1:0]    rsp_data1,
  output logic [TAG_WIDTH-1:0]     rsp_tag0,
  output logic [TAG_WIDTH-1:0]     rsp_tag1,
  output logic [CNT_WIDTH-1:0]     contention_cnt
);

  logic [1:0]               w_elig;
  logic [1:0]               w_grant;
  logic                     r_prio;
  logic [1:0]               r_rsp_valid;
  logic [DATA_WIDTH-1:0]    r_rsp_data0;
  logic [DATA_WIDTH-1:0]    r_rsp_data1;
  logic [TAG_WIDTH-1:0]     r_rsp_tag0;
  logic [TAG_WIDTH-1:0]     r_rsp_tag1;
  logic [CNT_WIDTH-1:0]     r_cnt;

  // A buffer that drains this cycle may be refilled in the same cycle.
  always_comb begin
    w_elig[0] = req_valid[0] && (!r_rsp_valid[0] || rsp_ready[0]);
    w_elig[1] = req_valid[1] && (!r_rsp_valid[1] || rsp_ready[1]);
    w_grant   = 2'b00;
    if (reset) begin
      w_grant = 2'b00;
    end else if (&w_elig) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end else begin
      w_grant = w_elig;
    end
  end

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (w_grant[0]) begin
      alu_op = req_op0;
      alu_a  = req_a0;
      alu_b  = req_b0;
    end else if (w_grant[1]) begin
      alu_op = req_op1;
      alu_a  = req_a1;
      alu_b  = req_b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio      <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_data0 <= '0;
      r_rsp_data1 <= '0;
      r_rsp_tag0  <= '0;
      r_rsp_tag1  <= '0;
      r_cnt       <= '0;
    end else begin
      // Favour whoever lost this cycle, giving strict alternation under contention.
      if (w_grant[0]) begin
        r_prio <= 1'b1;
      end else if (w_grant[1]) begin
        r_prio <= 1'b0;
      end

      if (w_grant[0]) begin
        r_rsp_data0    <= alu_result;
        r_rsp_tag0     <= req_tag0;
        r_rsp_valid[0] <= 1'b1;
      end else if (rsp_ready[0]) begin
        r_rsp_valid[0] <= 1'b0;
      end

      if (w_grant[1]) begin
        r_rsp_data1    <= alu_result;
        r_rsp_tag1     <= req_tag1;
        r_rsp_valid[1] <= 1'b1;
      end else if (rsp_ready[1]) begin
        r_rsp_valid[1] <= 1'b0;
      end

      if ((&w_elig) && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign req_ready      = w_grant;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data0      = r_rsp_data0;
  assign rsp_data1      = r_rsp_data1;
  assign rsp_tag0       = r_rsp_tag0;
  assign rsp_tag1       = r_rsp_tag1;
  assign contention_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Directed self-checking bench for alu_share_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [3:0]  req_tag0, req_tag1;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready, rsp_valid;
  logic [3:0]  alu_op, rsp_tag0, rsp_tag1;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data0, rsp_data1;
  logic [15:0] cnt;

  logic [1:0]  s_req_ready, s_rsp_valid;
  logic [3:0]  s_alu_op, s_rsp_tag0, s_rsp_tag1;
  logic [31:0] s_alu_a, s_alu_b, s_alu_result, s_rsp_data0, s_rsp_data1;
  logic [1:0]  s_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference ALU: AND, OR, ADD, SUB, equality compare.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      4'b0000: alu_f = a & b;
      4'b0001: alu_f = a | b;
      4'b0010: alu_f = a + b;
      4'b0110: alu_f = a - b;
      4'b1000: alu_f = {31'd0, a == b};
      default: alu_f = 32'd0;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_op, alu_a, alu_b);
  assign s_alu_result = alu_f(s_alu_op, s_alu_a, s_alu_b);

  alu_share_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(rsp_data0),
    .rsp_data1(rsp_data1), .rsp_tag0(rsp_tag0), .rsp_tag1(rsp_tag1),
    .contention_cnt(cnt)
  );

  alu_share_arbiter #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .alu_op(s_alu_op), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(s_rsp_data0),
    .rsp_data1(s_rsp_data1), .rsp_tag0(s_rsp_tag0), .rsp_tag1(s_rsp_tag1),
    .contention_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_op0 = 4'b0010; req_a0 = 32'd5; req_b0 = 32'd7; req_tag0 = 4'd3;
    req_op1 = 4'b0110; req_a1 = 32'd3; req_b1 = 32'd5; req_tag1 = 4'd9;
    tick();
    tick();
    check("reset_req_ready", {30'd0, req_ready}, 32'd0);
    check("reset_alu_op", {28'd0, alu_op}, 32'd0);
    check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("reset_data0", rsp_data0, 32'd0);
    check("reset_tag1", {28'd0, rsp_tag1}, 32'd0);
    check("reset_cnt", {16'd0, cnt}, 32'd0);

    // Idle after reset
    reset = 1'b0;
    req_valid = 2'b00;
    #1;
    check("idle0_alu_a", alu_a, 32'd0);
    check("idle0_req_ready", {30'd0, req_ready}, 32'd0);
    tick();

    // Contention: grants alternate 0,1,0,1 from reset priority
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    check("cont_cnt", {16'd0, cnt}, 32'd4);
    check("cont_data1", rsp_data1, 32'hFFFF_FFFE);
    check("cont_tag1", {28'd0, rsp_tag1}, 32'd9);
    check("cont_data0", rsp_data0, 32'd12);

    // Single requester
    req_valid = 2'b01;
    #1;
    check("single_req_ready", {30'd0, req_ready}, 32'd1);
    check("single_alu_a", alu_a, 32'd5);
    tick();
    check("single_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("single_data0", rsp_data0, 32'd12);
    check("single_tag0", {28'd0, rsp_tag0}, 32'd3);

    // Backpressure on requester 0; requester 1 keeps flowing
    rsp_ready = 2'b10;
    req_valid = 2'b11;
    req_op0 = 4'b0010; req_a0 = 32'd100; req_b0 = 32'd1; req_tag0 = 4'd7;
    req_op1 = 4'b0110; req_a1 = 32'd10;  req_b1 = 32'd4; req_tag1 = 4'd5;
    #1;
    check("bp_req_ready_a", {30'd0, req_ready}, 32'd2);
    tick();
    check("bp_data0_hold_a", rsp_data0, 32'd12);
    check("bp_data1_a", rsp_data1, 32'd6);
    req_a1 = 32'd20;
    #1;
    check("bp_req_ready_b", {30'd0, req_ready}, 32'd2);
    tick();
    check("bp_data0_hold_b", rsp_data0, 32'd12);
    check("bp_tag0_hold", {28'd0, rsp_tag0}, 32'd3);
    check("bp_data1_b", rsp_data1, 32'd16);
    check("bp_cnt", {16'd0, cnt}, 32'd4);
    rsp_ready = 2'b11;
    #1;
    check("bp_release_grant", {30'd0, req_ready}, 32'd1);
    tick();
    check("bp_release_data0", rsp_data0, 32'd101);
    check("bp_release_tag0", {28'd0, rsp_tag0}, 32'd7);
    check("bp_release_cnt", {16'd0, cnt}, 32'd5);

    // Drain-and-refill on requester 0
    rsp_ready = 2'b01;
    req_valid = 2'b01;
    req_op0 = 4'b1000; req_a0 = 32'd9; req_b0 = 32'd9;
    #1;
    check("refill_req_ready", {30'd0, req_ready}, 32'd1);
    tick();
    check("refill_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    check("refill_data0", rsp_data0, 32'd1);

    // Idle: no grant, priority (now requester 1) held
    req_valid = 2'b00;
    #1;
    check("idle_alu_op", {28'd0, alu_op}, 32'd0);
    check("idle_alu_b", alu_b, 32'd0);
    check("idle_req_ready", {30'd0, req_ready}, 32'd0);
    tick();
    check("idle_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    check("idle_prio_held", {30'd0, req_ready}, 32'd2);
    tick();

    // Fill both buffers, then reset mid-flight
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    tick();
    check("pre_reset_rsp_valid", {30'd0, rsp_valid}, 32'd3);
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    check("mid_reset_req_ready", {30'd0, req_ready}, 32'd0);
    check("mid_reset_alu_a", alu_a, 32'd0);
    tick();
    check("post_reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("post_reset_data1", rsp_data1, 32'd0);
    check("post_reset_tag0", {28'd0, rsp_tag0}, 32'd0);
    check("post_reset_cnt", {16'd0, cnt}, 32'd0);

    // Five contended cycles: first grant to 0, narrow counter saturates at 3
    reset = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("sat_grant", {30'd0, req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
    end
    check("sat_cnt_wide", {16'd0, cnt}, 32'd5);
    check("sat_cnt_narrow", {30'd0, s_cnt}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
